// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/ack memory port, and holds a single instruction for ID to consume.
`ifndef INST_TYPE_NONE
`define INST_TYPE_NONE 4'd0
`define INST_TYPE_R    4'd1
`define INST_TYPE_I    4'd2
`define INST_TYPE_J    4'd3
`endif

module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        cu_wpcir,
    input  logic        cu_branch,
    input  logic [31:0] ID_new_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic [3:0]  IF_ins_type,
    output logic [3:0]  IF_ins_number
);

    // S_FULL doubles as the buffer-valid flag; S_DRAIN waits out a request
    // whose address was abandoned by a redirect.
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FULL} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drain_addr;
    logic [31:0] ibuf;
    logic [3:0]  count;
    logic [31:0] target;

    assign target = ID_new_pc & 32'hFFFF_FFFC;

    // Fetch/redirect/consume state machine; all architectural state lives here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            ibuf       <= 32'h0;
            count      <= 4'd0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack && !cu_branch) begin
                        ibuf  <= imem_rdata;
                        state <= S_FULL;
                    end else if (cu_branch) begin
                        pc <= target;
                        // Without ack the old request is still in flight and
                        // its address must stay on the bus until it completes.
                        if (!imem_ack) begin
                            drain_addr <= pc;
                            state      <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cu_branch) pc <= target;
                    if (imem_ack) state <= S_FETCH;
                end
                S_FULL: begin
                    if (cu_branch) begin
                        pc    <= target;
                        state <= S_FETCH;
                    end else if (!cu_wpcir) begin
                        pc    <= pc + 32'd4;
                        count <= count + 4'd1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Output decode from state; reset clears state so req drops immediately.
    always_comb begin
        imem_req    = (state == S_FETCH) || (state == S_DRAIN);
        imem_addr   = (state == S_DRAIN) ? drain_addr : pc;
        if_pc4      = pc + 32'd4;
        if_inst     = 32'h0;
        IF_ins_type = `INST_TYPE_NONE;
        if (state == S_FULL) begin
            if_inst = ibuf;
            case (ibuf[31:26])
                6'h00:        IF_ins_type = `INST_TYPE_R;
                6'h02, 6'h03: IF_ins_type = `INST_TYPE_J;
                default:      IF_ins_type = `INST_TYPE_I;
            endcase
        end
    end

    assign IF_ins_number = count;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: variable-latency memory, random stall and
// redirect, scoreboard of the instruction ID should see next.
`ifndef INST_TYPE_NONE
`define INST_TYPE_NONE 4'd0
`define INST_TYPE_R    4'd1
`define INST_TYPE_I    4'd2
`define INST_TYPE_J    4'd3
`endif

module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, ID_new_pc, if_inst, if_pc4;
    logic        cu_wpcir, cu_branch;
    logic [3:0]  IF_ins_type, IF_ins_number;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .cu_wpcir(cu_wpcir), .cu_branch(cu_branch), .ID_new_pc(ID_new_pc),
        .if_inst(if_inst), .if_pc4(if_pc4),
        .IF_ins_type(IF_ins_type), .IF_ins_number(IF_ins_number)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [3:0]  num;
        logic [3:0]  typ;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [31:0] pc_m;
    logic [3:0]  cnt_m;
    int          mode, max_lat, wait_left, since, idle_run;
    bit          req_active;
    logic [31:0] req_addr;

    // Memory image: mode 1 is addr|0x2000_0000, mode 0 mixes R/J/I opcodes.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [5:0] ops [0:4];
        ops = '{6'h00, 6'h02, 6'h03, 6'h23, 6'h08};
        if (mode == 1) return a | 32'h2000_0000;
        return {ops[(a >> 2) % 5], a[27:2] ^ 26'h2AA_AAAA};
    endfunction

    function automatic logic [3:0] type_of(input logic [31:0] w);
        if (w[31:26] == 6'h00) return `INST_TYPE_R;
        if (w[31:26] == 6'h02 || w[31:26] == 6'h03) return `INST_TYPE_J;
        return `INST_TYPE_I;
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        e.inst = mem_word(pc_m);
        e.pc4  = pc_m + 32'd4;
        e.num  = cnt_m;
        e.typ  = type_of(e.inst);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: whatever ID sees must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (IF_ins_type != `INST_TYPE_NONE) begin
                if (exp_q.size() == 0) begin
                    check("sb_nonempty", 32'h0, 32'h1);
                end else begin
                    check("if_inst", if_inst, exp_q[0].inst);
                    check("if_pc4", if_pc4, exp_q[0].pc4);
                    check("ins_number", {28'h0, IF_ins_number}, {28'h0, exp_q[0].num});
                    check("ins_type", {28'h0, IF_ins_type}, {28'h0, exp_q[0].typ});
                end
                check("no_req_when_full", {31'h0, imem_req}, 32'h0);
            end else begin
                check("bubble_inst", if_inst, 32'h0);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc4", if_pc4, RESET_PC + 32'd4);
        check("rst_type", {28'h0, IF_ins_type}, {28'h0, `INST_TYPE_NONE});
        check("rst_number", {28'h0, IF_ins_number}, 32'h0);
    endtask

    task automatic finish_reset();
        cu_wpcir = 0; cu_branch = 0; imem_ack = 0; req_active = 0;
        @(negedge clk); #1;
        check_reset_outputs();
        rst = 0;
        pc_m = RESET_PC; cnt_m = 0;
        exp_q.delete(); exp_q.push_back(make_exp());
        since = 0; idle_run = 0;
    endtask

    // One cycle: memory responds, then random stall/redirect and model update.
    task automatic step(input int stall_pct, input int br_pct);
        bit valid;
        @(negedge clk); #1;
        if (imem_req) begin
            if (!req_active) begin
                req_active = 1; req_addr = imem_addr;
                wait_left = $urandom_range(0, max_lat);
            end else begin
                check("addr_stable", imem_addr, req_addr);
            end
            if (wait_left == 0) begin
                imem_ack = 1; imem_rdata = mem_word(imem_addr); req_active = 0;
            end else begin
                imem_ack = 0; imem_rdata = $urandom; wait_left--;
            end
        end else begin
            imem_ack = 0; req_active = 0;
        end
        valid     = (IF_ins_type != `INST_TYPE_NONE);
        cu_wpcir  = ($urandom_range(0, 99) < stall_pct);
        cu_branch = (since >= 1) && ($urandom_range(0, 99) < br_pct);
        case ($urandom_range(0, 2))
            0:       ID_new_pc = $urandom & 32'h0000_0FFF;
            1:       ID_new_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            default: ID_new_pc = $urandom;
        endcase
        if (cu_branch) begin
            pc_m = ID_new_pc & 32'hFFFF_FFFC;
            exp_q.delete(); exp_q.push_back(make_exp());
            idle_run = 0;
        end else if (valid && !cu_wpcir) begin
            void'(exp_q.pop_front());
            pc_m = pc_m + 32'd4; cnt_m = cnt_m + 4'd1;
            exp_q.push_back(make_exp());
            idle_run = 0;
        end else if (valid) begin
            idle_run = 0;
        end else begin
            idle_run++;
            if (idle_run > 20) begin
                checks++; errors++;
                $display("FAIL progress: no instruction for %0d cycles, expected <= 20", idle_run);
                idle_run = 0;
            end
        end
        since++;
    endtask

    initial begin
        cu_wpcir = 0; cu_branch = 0; ID_new_pc = 0; imem_ack = 0; imem_rdata = 0;
        req_active = 0; wait_left = 0; since = 0; idle_run = 0;
        pc_m = RESET_PC; cnt_m = 0;

        // Zero-wait, no stall: requests 0,4,8 on alternate cycles.
        mode = 1; max_lat = 0; rst = 1;
        #2 check_reset_outputs();
        finish_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            check("t1_req", {31'h0, imem_req}, (i % 2 == 0) ? 32'h1 : 32'h0);
            if (i % 2 == 0) check("t1_addr", imem_addr, RESET_PC + 32'(i / 2) * 32'd4);
        end
        for (int i = 0; i < 40; i++) step(20, 0);

        // Mixed latency, stalls and redirects.
        rst = 1; mode = 0; max_lat = 3;
        finish_reset();
        for (int i = 0; i < 3000; i++) step(30, 10);

        // Reset while a request is outstanding: req must drop at once.
        for (int i = 0; i < 50 && !imem_req; i++) step(0, 0);
        #3 rst = 1;
        #1 check("midreq_rst_req", {31'h0, imem_req}, 32'h0);
        check_reset_outputs();
        max_lat = 1;
        finish_reset();
        for (int i = 0; i < 3; i++) step(0, 0);

        // Long unstalled run so the sequence number wraps many times.
        for (int i = 0; i < 300; i++) step(0, 0);

        // Redirect-heavy with slow memory to exercise draining.
        max_lat = 3;
        for (int i = 0; i < 1500; i++) step(25, 40);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
